// File: rtl/shift_unit.sv
// shift_unit -- iterative barrel-less shifter.
//
// Shifts or rotates an XLEN-bit operand by an unsigned amount, moving at most
// STEP bit positions per clock. A zero amount or a reserved op code completes
// immediately and returns the operand unchanged.
//
// Configuration macro: SHIFTER_ROTATE_EN
//   defined   -> op codes 011 (ROL) and 100 (ROR) rotate the operand
//   undefined -> 011 and 100 are reserved and no rotate logic is built
//
// Parameters:
//   XLEN  operand/result width (32 or 64)
//   STEP  maximum bit positions shifted per clock (power of two, 1..XLEN/2)
//
// Ports:
//   i_clk_n   clock, registers update on its rising edge
//   i_rst_n   synchronous active-low reset
//   i_start   request a new operation (accepted only when idle)
//   i_kill    abort the operation in flight / cancel a same-cycle start
//   i_op      000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved
//   i_in_a    value to shift
//   i_in_b    shift amount, unsigned
//   o_result  result, held until the next accepted start
//   o_busy    high while an operation is running
//   o_valid   one-cycle pulse when o_result is final
module shift_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic                    i_clk_n,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_kill,
  input  logic [2:0]              i_op,
  input  logic [XLEN-1:0]         i_in_a,
  input  logic [$clog2(XLEN)-1:0] i_in_b,
  output logic [XLEN-1:0]         o_result,
  output logic                    o_busy,
  output logic                    o_valid
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
`ifdef SHIFTER_ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic [CW-1:0]   remaining_reg, remaining_next;
  logic [2:0]      op_reg, op_next;
  logic            valid_reg, valid_next;

  logic [CW-1:0]   step_amt;
  logic [XLEN-1:0] shifted;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFTER_ROTATE_EN
    return (op <= 3'b100);
`else
    return (op <= 3'b010);
`endif
  endfunction

  // Bits moved this cycle: the full step, or whatever is left if smaller.
  assign step_amt = (remaining_reg > STEP_C) ? STEP_C : remaining_reg;

`ifdef SHIFTER_ROTATE_EN
  // Rotates use a doubled copy of the value so the bits shifted out of one
  // end land in the vacated positions at the other end.
  logic [2*XLEN-1:0] rol_wide;
  logic [2*XLEN-1:0] ror_wide;
  assign rol_wide = {result_reg, result_reg} << step_amt;
  assign ror_wide = {result_reg, result_reg} >> step_amt;
`endif

  always_comb begin
    shifted = result_reg;
    case (op_reg)
      OP_SLL:  shifted = result_reg << step_amt;
      OP_SRL:  shifted = result_reg >> step_amt;
      // The sign bit never changes during SRA, so re-extending the current
      // value each step replicates the originally captured bit XLEN-1.
      OP_SRA:  shifted = $signed(result_reg) >>> step_amt;
`ifdef SHIFTER_ROTATE_EN
      OP_ROL:  shifted = rol_wide[2*XLEN-1:XLEN];
      OP_ROR:  shifted = ror_wide[XLEN-1:0];
`endif
      default: shifted = result_reg;
    endcase
  end

  always_ff @(posedge i_clk_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      result_reg    <= '0;
      remaining_reg <= '0;
      op_reg        <= '0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      result_reg    <= result_next;
      remaining_reg <= remaining_next;
      op_reg        <= op_next;
      valid_reg     <= valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    result_next    = result_reg;
    remaining_next = remaining_reg;
    op_next        = op_reg;
    valid_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        // A start is not taken in the cycle o_valid is high, so a caller
        // holding i_start does not silently launch a second operation.
        if (i_start && !i_kill && !valid_reg) begin
          result_next    = i_in_a;
          remaining_next = i_in_b;
          op_next        = i_op;
          if ((i_in_b == '0) || !op_legal(i_op)) begin
            valid_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (i_kill) begin
          state_next     = IDLE;
          remaining_next = '0;
        end else begin
          result_next    = shifted;
          remaining_next = remaining_reg - step_amt;
          if (remaining_reg == step_amt) begin
            state_next = IDLE;
            valid_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_result = result_reg;
  assign o_busy   = (state_reg == RUN);
  assign o_valid  = valid_reg;

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit -- drives two shift_unit instances (STEP=1 and STEP=4, both
// XLEN=32) with identical stimulus and compares them against a plain
// arithmetic model of each operation and its cycle count.
module tb_shift_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] in_a;
  logic [4:0]  in_b;

  logic [31:0] res_s1, res_s4;
  logic        busy_s1, busy_s4;
  logic        valid_s1, valid_s4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shift_unit #(.XLEN(32), .STEP(1)) u_dut_s1 (
    .i_clk_n  (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_kill   (kill),
    .i_op     (op),
    .i_in_a   (in_a),
    .i_in_b   (in_b),
    .o_result (res_s1),
    .o_busy   (busy_s1),
    .o_valid  (valid_s1)
  );

  shift_unit #(.XLEN(32), .STEP(4)) u_dut_s4 (
    .i_clk_n  (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_kill   (kill),
    .i_op     (op),
    .i_in_a   (in_a),
    .i_in_b   (in_b),
    .o_result (res_s4),
    .o_busy   (busy_s4),
    .o_valid  (valid_s4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_legal(input logic [2:0] o);
`ifdef SHIFTER_ROTATE_EN
    return (o <= 3'd4);
`else
    return (o <= 3'd2);
`endif
  endfunction

  function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] a, input int b);
    if (b == 0 || !ref_legal(o)) return a;
    case (o)
      3'd0:    return a << b;
      3'd1:    return a >> b;
      3'd2:    return $signed(a) >>> b;
      3'd3:    return (a << b) | (a >> (32 - b));
      3'd4:    return (a >> b) | (a << (32 - b));
      default: return a;
    endcase
  endfunction

  // Edges from the accept edge to the edge that raises o_valid.
  function automatic int ref_latency(input logic [2:0] o, input int b, input int step);
    if (b == 0 || !ref_legal(o)) return 0;
    return (b + step - 1) / step;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "/res1"},   res_s1,   32'h0);
    check({tag, "/res4"},   res_s4,   32'h0);
    check({tag, "/busy1"},  busy_s1,  32'h0);
    check({tag, "/busy4"},  busy_s4,  32'h0);
    check({tag, "/valid1"}, valid_s1, 32'h0);
    check({tag, "/valid4"}, valid_s4, 32'h0);
  endtask

  // One full operation on both units, checking busy/valid every cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [4:0] b);
    logic [31:0] exp;
    int lat1;
    int lat4;
    exp  = ref_shift(o, a, int'(b));
    lat1 = ref_latency(o, int'(b), 1);
    lat4 = ref_latency(o, int'(b), 4);
    op    = o;
    in_a  = a;
    in_b  = b;
    start = 1'b1;
    tick();
    // Scramble the operands: they must already be latched.
    op   = 3'($urandom_range(0, 7));
    in_a = $urandom;
    in_b = 5'($urandom);
    for (int k = 0; k <= lat1; k++) begin
      check({tag, "/busy1"},  busy_s1,  32'(k < lat1));
      check({tag, "/valid1"}, valid_s1, 32'(k == lat1));
      check({tag, "/busy4"},  busy_s4,  32'(k < lat4));
      check({tag, "/valid4"}, valid_s4, 32'(k == lat4));
      if (k == lat1) check({tag, "/res1"}, res_s1, exp);
      if (k == lat4) check({tag, "/res4"}, res_s4, exp);
      // Stray starts while both units are busy or pulsing valid are ignored.
      start = (k <= lat4) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    start = 1'b0;
    check({tag, "/post_valid1"}, valid_s1, 32'h0);
    check({tag, "/post_valid4"}, valid_s4, 32'h0);
    check({tag, "/post_busy1"},  busy_s1,  32'h0);
    check({tag, "/post_busy4"},  busy_s4,  32'h0);
    check({tag, "/hold_res1"},   res_s1,   exp);
    check({tag, "/hold_res4"},   res_s4,   exp);
    $display("%s: op=%0d a=0x%08h b=%0d -> s1=0x%08h s4=0x%08h", tag, o, a, b, res_s1, res_s4);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    kill  = 1'b0;
    op    = 3'd0;
    in_a  = 32'h0;
    in_b  = 5'd0;
    tick();
    tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;

    run_op("sra_31",      3'd2, 32'h8000_0000, 5'd31);
    check("sra_31/const", res_s4, 32'hFFFF_FFFF);
    run_op("sll_13",      3'd0, 32'h0000_0001, 5'd13);
    check("sll_13/const", res_s4, 32'h0000_2000);
    run_op("srl_b0",      3'd1, 32'hDEAD_BEEF, 5'd0);
    run_op("ror_8",       3'd4, 32'h0123_4567, 5'd8);
    run_op("rol_3",       3'd3, 32'h8765_4321, 5'd3);
    run_op("rsv_6",       3'd6, 32'hCAFE_F00D, 5'd9);
    run_op("sll_31",      3'd0, 32'hFFFF_FFFF, 5'd31);
    run_op("srl_4",       3'd1, 32'h1234_5678, 5'd4);

    // Kill on the fifth RUN cycle: back to IDLE with no valid pulse.
    op    = 3'd0;
    in_a  = $urandom;
    in_b  = 5'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("kill/busy4_before", busy_s4, 32'h1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill/busy1",  busy_s1,  32'h0);
    check("kill/busy4",  busy_s4,  32'h0);
    check("kill/valid1", valid_s1, 32'h0);
    check("kill/valid4", valid_s4, 32'h0);
    tick();
    check("kill/late_valid1", valid_s1, 32'h0);
    check("kill/late_valid4", valid_s4, 32'h0);
    $display("kill: SLL b=20 aborted in RUN cycle 5");
    run_op("after_kill", 3'd1, 32'h0000_00F0, 5'd4);
    check("after_kill/const", res_s1, 32'h0000_000F);

    // Kill together with start in IDLE cancels the start.
    op    = 3'd1;
    in_a  = 32'hFFFF_0000;
    in_b  = 5'd0;
    start = 1'b1;
    kill  = 1'b1;
    tick();
    start = 1'b0;
    kill  = 1'b0;
    check("kill_start/valid1", valid_s1, 32'h0);
    check("kill_start/valid4", valid_s4, 32'h0);
    check("kill_start/res1",   res_s1,   32'h0000_000F);
    $display("kill_start: start cancelled");

    // Reset during the third RUN cycle.
    op    = 3'd2;
    in_a  = $urandom | 32'h8000_0000;
    in_b  = 5'd31;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_outputs_zero("rst_run");
    rst_n = 1'b1;
    tick();
    check("rst_run/valid1", valid_s1, 32'h0);
    check("rst_run/valid4", valid_s4, 32'h0);
    $display("rst_run: reset in RUN cycle 3");
    run_op("after_rst", 3'd0, 32'h0000_00A5, 5'd7);

    for (int i = 0; i < 30; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), $urandom, 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width; legal values 32 and 64.
REQ-002 SHALL have parameter STEP, default 1, meaning maximum bit positions shifted per cycle; legal values are powers of two from 1 to XLEN/2.
REQ-003 SHALL have port i_clk_n  input  1  clock; all registers update on the rising edge of i_clk_n.
REQ-004 SHALL have port i_rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port i_start  input  1  request a new operation.
REQ-006 SHALL have port i_kill  input  1  abort the operation in flight (pipeline flush).
REQ-007 SHALL have port i_op  input  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 reserved.
REQ-008 SHALL have port i_in_a  input  XLEN  value to shift.
REQ-009 SHALL have port i_in_b  input  log2(XLEN)  shift amount, unsigned.
REQ-010 SHALL have port o_result  output  XLEN  result, held until the next accepted start.
REQ-011 SHALL have port o_busy  output  1  high while an operation is in progress.
REQ-012 SHALL have port o_valid  output  1  single-cycle pulse when o_result is final.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN; o_busy is 1 exactly in RUN.
REQ-014 In IDLE, i_start=1 with i_kill=0 SHALL be accepted: it captures i_in_a into the result register, i_in_b into the remaining-count register, and i_op.
REQ-015 On accept, if i_in_b=0 or i_op is reserved, the FSM SHALL stay in IDLE, o_result SHALL equal i_in_a, and o_valid SHALL pulse in the next cycle.
REQ-016 On accept, if i_in_b is nonzero and i_op is legal, the FSM SHALL enter RUN.
REQ-017 In RUN, each clock SHALL shift the result by n = min(STEP, remaining) and decrement remaining by n.
REQ-018 When remaining reaches 0, the FSM SHALL return to IDLE and assert o_valid for exactly one cycle.
REQ-019 Latency SHALL be ceil(amount/STEP) clocks from the accept edge to the edge that raises o_valid.
REQ-020 Vacated bits SHALL be filled as follows: SLL and SRL fill with 0; SRA fills with the captured bit XLEN-1; ROL and ROR fill with the bits shifted out.
REQ-021 i_start SHALL be ignored while in RUN, and in the cycle o_valid is high; no operation is queued.
REQ-022 i_kill in RUN SHALL force IDLE at the next edge with no o_valid pulse; o_result is then don't-care.
REQ-023 i_kill together with i_start in IDLE SHALL cancel the start.
REQ-024 i_kill SHALL NOT suppress an o_valid pulse that is already high.
REQ-025 Input ports other than i_start and i_kill SHALL be sampled only on the accept edge, so callers may change them afterwards.

Reset
REQ-026 While i_rst_n=0 at a rising edge, the block SHALL clear the FSM to IDLE and set o_result=0, o_busy=0, o_valid=0, and remaining=0.
REQ-027 Reset asserted in RUN SHALL abort the operation with no o_valid pulse.
REQ-028 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-029 Macro SHIFTER_ROTATE_EN defined: ROL and ROR SHALL operate as specified in REQ-020.
REQ-030 Macro SHIFTER_ROTATE_EN undefined: op codes 011 and 100 SHALL be treated as reserved (REQ-015), and the rotate datapath SHALL be absent from synthesis.

Verification
REQ-031 XLEN=32, STEP=1, SRA, a=0x80000000, b=31 -> o_busy high for 31 cycles, then o_valid pulse with o_result=0xFFFFFFFF.
REQ-032 XLEN=32, STEP=4, SLL, a=0x00000001, b=13 -> o_valid 4 clocks after accept, o_result=0x00002000.
REQ-033 XLEN=64, STEP=8, ROR (SHIFTER_ROTATE_EN defined), a=0x0123456789ABCDEF, b=8 -> o_valid 1 clock after accept, o_result=0xEF0123456789ABCD; same stimulus with the macro undefined -> o_result=a after 1 cycle.
REQ-034 STEP=1, SRL, b=0, a=0xDEADBEEF -> o_busy never high, o_valid next cycle, o_result=0xDEADBEEF.
REQ-035 Start SLL b=20, then i_kill on the 5th RUN cycle -> IDLE next edge with no o_valid; a following start of SRL a=0xF0, b=4 returns 0x0F.
REQ-036 i_rst_n low in the 3rd RUN cycle -> all outputs 0 next edge; i_start pulses while busy are ignored, so exactly one o_valid pulse per accepted start.
